axi_mem_sub: RTL
================

AXI_MEM_SUB -- requirements
Module: axi_mem_sub

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024, meaning the number of 64-bit words (power of two).
REQ-002 SHALL have parameter READ_LATENCY, default 1, meaning the cycles from AR handshake to rvalid (range 1..15).
REQ-003 SHALL have parameter STALL_SEED, default 32'h1, meaning the non-zero LFSR seed (used only under AXI_MEM_SUB_STALL_EN).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; every process is clocked on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports i_axi_s_aw (input, axi_aw_t), o_axi_s_awready (output, 1), and i_axi_s_awvalid (input, 1): the write-address channel.
REQ-007 SHALL have ports i_axi_s_w (input, axi_w_t), o_axi_s_wready (output, 1), and i_axi_s_wvalid (input, 1): the write-data channel.
REQ-008 SHALL have ports o_axi_s_b (output, axi_b_t), i_axi_s_bready (input, 1), and o_axi_s_bvalid (output, 1): the write-response channel.
REQ-009 SHALL have ports i_axi_s_ar (input, axi_ar_t), o_axi_s_arready (output, 1), and i_axi_s_arvalid (input, 1): the read-address channel.
REQ-010 SHALL have ports o_axi_s_r (output, axi_r_t), i_axi_s_rready (input, 1), and o_axi_s_rvalid (output, 1): the read-data channel.

Function
REQ-011 SHALL implement a single-beat AXI subordinate backed by MEM_DEPTH x AXI_DATA_WIDTH storage, word index = addr[3 +: $clog2(MEM_DEPTH)]; upper address bits are ignored.
REQ-012 SHALL run the write FSM W_IDLE -> W_DATA on AW handshake, W_DATA -> W_RESP on W handshake, and W_RESP -> W_IDLE on B handshake.
REQ-013 SHALL assert awready only in W_IDLE and wready only in W_DATA; a W presented before its AW is not accepted.
REQ-014 SHALL latch AW id/addr/len/size at the AW handshake and capture W on the W handshake; the memory write commits at the W handshake, honouring strb per byte.
REQ-015 SHALL set b.resp=OKAY(2'b00) when len==0 and size==3; otherwise b.resp=SLVERR(2'b10) and memory is left unchanged; b.id = latched AW id.
REQ-016 SHALL run the read FSM R_IDLE -> R_WAIT on AR handshake, R_WAIT -> R_RESP after READ_LATENCY-1 further cycles (directly to R_RESP when READ_LATENCY==1), and R_RESP -> R_IDLE on R handshake.
REQ-017 SHALL assert arready only in R_IDLE; rvalid only in R_RESP; r.id = AR id, r.last=1, r.resp per the REQ-015 rule applied to ar.len/ar.size, and r.data='0 on SLVERR.
REQ-018 SHALL sample read data from memory on the cycle it enters R_RESP and hold r stable until the handshake.
REQ-019 SHALL, when a write commits in the same cycle a read samples the same word, return the old (pre-write) data.
REQ-020 SHALL run the read and write FSMs independently; each allows one outstanding transaction, with no reordering.
REQ-021 SHALL hold valid outputs asserted and payload stable until the handshake (AXI rule); deasserting bready or rready stalls indefinitely.

Reset
REQ-022 SHALL, while rst is high, place both FSMs in IDLE and drive awready=arready=1 and wready=bvalid=rvalid=0, with b and r payloads at '0; deasserting rst re-enables them on the next cycle.
REQ-023 SHALL abandon in-flight transactions when rst asserts mid-operation, with no memory write for an uncommitted W; memory contents SHALL NOT be reset (unwritten words read X in simulation).

Configuration
REQ-024 SHALL, with AXI_MEM_SUB_STALL_EN defined, gate awready, wready and arready with bits [0], [1] and [2] of a 32-bit Galois LFSR (seeded STALL_SEED at reset, advancing every cycle); a low bit forces its ready low that cycle.
REQ-025 SHALL, without AXI_MEM_SUB_STALL_EN, omit the LFSR logic so that readies follow REQ-013/REQ-017 exactly.

Structure
REQ-026 SHALL take axi_aw_t/axi_w_t/axi_b_t/axi_ar_t/axi_r_t, AXI_ADDR/DATA/ID_WIDTH and new resp constants RESP_OKAY/RESP_SLVERR from axi_pkg.
REQ-027 SHALL place the storage array in sub-module axi_mem_sub_ram (1 write port with byte enables, 1 synchronous read port); FSMs and LFSR SHALL stay in the top level.

Verification
REQ-028 SHALL be verified by: write addr 0x40, data 0x1122334455667788, strb 0xFF -> bresp 0 and bid = awid; read 0x40 -> rdata 0x1122334455667788 after READ_LATENCY cycles.
REQ-029 SHALL be verified by: write 0x40 with strb 0x0F and data 0xAAAAAAAAAAAAAAAA over the prior word -> read returns 0x11223344AAAAAAAA.
REQ-030 SHALL be verified by: AW with len=1 -> bresp 2'b10 and memory unchanged; AR with size=2 -> rresp 2'b10 and rdata 0.
REQ-031 SHALL be verified by: holding bready and rready low for 20 cycles -> bvalid and rvalid held with stable payload, and no new AW/AR accepted.
REQ-032 SHALL be verified by: a same-cycle W commit and read sample on 0x80 (old 0x5, new 0x9) -> read returns 0x5, and a subsequent read returns 0x9.
REQ-033 SHALL be verified by: asserting rst in W_DATA after an accepted AW to 0x100 -> no write, bvalid=0, and awready=1 after reset.

Source files
------------

// File: rtl/axi_mem_sub_pkg.sv
// FSM state encodings and the single-beat legality rule for axi_mem_sub.
// Pure definitions: no latency or flow-control content.
package axi_mem_sub_pkg;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    // Only one full-width (8-byte) beat per burst is supported.
    function automatic logic beat_ok(input logic [7:0] len, input logic [2:0] size);
        return (len == 8'd0) && (size == 3'd3);
    endfunction

endpackage

// File: rtl/axi_pkg.sv
// Shared AXI4 channel types, widths and response codes.
// Payload-only structs: valid/ready travel as separate 1-bit ports.
package axi_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 64;
    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
    } axi_aw_t;

    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [AXI_STRB_WIDTH-1:0] strb;
        logic                      last;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0] id;
        logic [1:0]              resp;
    } axi_b_t;

    typedef axi_aw_t axi_ar_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [1:0]                resp;
        logic                      last;
    } axi_r_t;

endpackage

// File: rtl/axi_mem_sub_ram.sv
// Word storage: one byte-enabled write port, one registered read port.
// Read data appears the cycle after re; a same-cycle write to that word returns old data.
// No backpressure; contents are never reset.
module axi_mem_sub_ram
    import axi_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [AXI_DATA_WIDTH-1:0]  wdata,
    input  logic [AXI_STRB_WIDTH-1:0]  wstrb,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [AXI_DATA_WIDTH-1:0]  rdata
);

    logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < AXI_STRB_WIDTH; i++) begin
                if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi_mem_sub.sv
// Single-beat AXI4 subordinate over a MEM_DEPTH x 64-bit RAM; optional ready stalls via AXI_MEM_SUB_STALL_EN.
// Latency: B one cycle after W handshake; R READ_LATENCY cycles after AR handshake.
// Backpressure: one outstanding read and one write; bvalid/rvalid hold until bready/rready.
module axi_mem_sub
    import axi_pkg::*;
    import axi_mem_sub_pkg::*;
#(
    parameter int unsigned MEM_DEPTH    = 1024,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [31:0] STALL_SEED   = 32'h1
) (
    input  logic    clk,
    input  logic    rst,
    input  axi_aw_t i_axi_s_aw,
    output logic    o_axi_s_awready,
    input  logic    i_axi_s_awvalid,
    input  axi_w_t  i_axi_s_w,
    output logic    o_axi_s_wready,
    input  logic    i_axi_s_wvalid,
    output axi_b_t  o_axi_s_b,
    input  logic    i_axi_s_bready,
    output logic    o_axi_s_bvalid,
    input  axi_ar_t i_axi_s_ar,
    output logic    o_axi_s_arready,
    input  logic    i_axi_s_arvalid,
    output axi_r_t  o_axi_s_r,
    input  logic    i_axi_s_rready,
    output logic    o_axi_s_rvalid
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [3:0] WAIT_INIT = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [AXI_ID_WIDTH-1:0] aw_id, ar_id;
    logic [IDX_W-1:0]        aw_idx, ar_idx, ram_raddr;
    logic                    aw_ok, ar_ok;
    logic [3:0]              wait_cnt;
    logic                    ram_re, ram_we;
    logic [AXI_DATA_WIDTH-1:0] ram_rdata;
    logic [2:0]              gate;
    logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;

`ifdef AXI_MEM_SUB_STALL_EN
    logic [31:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) lfsr <= STALL_SEED;
        else     lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
    end

    assign gate = lfsr[2:0];
`else
    logic unused_seed;
    assign unused_seed = ^STALL_SEED;
    assign gate        = 3'b111;
`endif

    assign o_axi_s_awready = (w_state == W_IDLE) & gate[0];
    assign o_axi_s_wready  = (w_state == W_DATA) & gate[1];
    assign o_axi_s_arready = (r_state == R_IDLE) & gate[2];
    assign o_axi_s_bvalid  = (w_state == W_RESP);
    assign o_axi_s_rvalid  = (r_state == R_RESP);

    assign aw_hs = i_axi_s_awvalid & o_axi_s_awready;
    assign w_hs  = i_axi_s_wvalid  & o_axi_s_wready;
    assign b_hs  = o_axi_s_bvalid  & i_axi_s_bready;
    assign ar_hs = i_axi_s_arvalid & o_axi_s_arready;
    assign r_hs  = o_axi_s_rvalid  & i_axi_s_rready;

    // A W caught in flight by reset must never reach the array.
    assign ram_we = w_hs & aw_ok & ~rst;

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs)  w_next = W_RESP;
            W_RESP:  if (b_hs)  w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            aw_id   <= '0;
            aw_idx  <= '0;
            aw_ok   <= 1'b0;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                aw_id  <= i_axi_s_aw.id;
                aw_idx <= i_axi_s_aw.addr[3 +: IDX_W];
                aw_ok  <= beat_ok(i_axi_s_aw.len, i_axi_s_aw.size);
            end
        end
    end

    // RAM read is issued on the edge that enters R_RESP so its output is ready with rvalid.
    always_comb begin
        r_next = r_state;
        ram_re = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    if (READ_LATENCY == 1) begin
                        r_next = R_RESP;
                        ram_re = 1'b1;
                    end else begin
                        r_next = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    r_next = R_RESP;
                    ram_re = 1'b1;
                end
            end
            R_RESP:  if (r_hs) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    assign ram_raddr = (r_state == R_IDLE) ? i_axi_s_ar.addr[3 +: IDX_W] : ar_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= R_IDLE;
            ar_id    <= '0;
            ar_idx   <= '0;
            ar_ok    <= 1'b0;
            wait_cnt <= 4'd0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                ar_id    <= i_axi_s_ar.id;
                ar_idx   <= i_axi_s_ar.addr[3 +: IDX_W];
                ar_ok    <= beat_ok(i_axi_s_ar.len, i_axi_s_ar.size);
                wait_cnt <= WAIT_INIT;
            end else if (r_state == R_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        o_axi_s_b = '0;
        if (w_state == W_RESP) begin
            o_axi_s_b.id   = aw_id;
            o_axi_s_b.resp = aw_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_comb begin
        o_axi_s_r = '0;
        if (r_state == R_RESP) begin
            o_axi_s_r.id   = ar_id;
            o_axi_s_r.data = ar_ok ? ram_rdata : '0;
            o_axi_s_r.resp = ar_ok ? RESP_OKAY : RESP_SLVERR;
            o_axi_s_r.last = 1'b1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{i_axi_s_aw.addr, i_axi_s_ar.addr, i_axi_s_w.last};

    axi_mem_sub_ram #(.DEPTH(MEM_DEPTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (aw_idx),
        .wdata (i_axi_s_w.data),
        .wstrb (i_axi_s_w.strb),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

endmodule
